video_in_wb_writer: RTL and testbench
=====================================

# video_in_wb_writer

Drain side of the video-in pixel FIFO. It waits until the FIFO reports a full packet of `NB_PACK` words, pops them one by one, and writes them to system memory as a Wishbone master burst at consecutive word addresses. Addresses run from a per-frame base address and wrap after `FRAME_WORDS` words, producing one contiguous frame buffer per frame. It sits between the video-in FIFO read port and the system Wishbone interconnect.

## Interface
Clock `clk`, one domain. Reset `nRST` is asynchronous and active-low.

Parameters:
- `DATA_SIZE`, 32: FIFO word and Wishbone data width; must be 32.
- `NB_PACK`, 16: words per packet, which is also the burst length.
- `FRAME_WORDS`, 76800: words per frame; must be a multiple of `NB_PACK`.
- `FIFO_LAT`, 2: cycles from a `fifo_r_ack` pulse until the new head word is valid on `fifo_data`.

Ports:
- `clk` in 1: clock.
- `nRST` in 1: asynchronous active-low reset.
- `enable` in 1: when low, no new packet is started.
- `frame_base` in 32: byte base address of the frame buffer, word-aligned.
- `fifo_data` in DATA_SIZE: FIFO head word.
- `fifo_pack_available` in 1: the FIFO holds at least `NB_PACK` words.
- `fifo_r_ack` out 1: one-cycle pop pulse.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1 each: Wishbone master controls.
- `wb_adr_o` out 32: byte address.
- `wb_dat_o` out DATA_SIZE: write data.
- `wb_sel_o` out 4: byte selects.
- `wb_cti_o` out 3: cycle type identifier.
- `wb_bte_o` out 2: burst type extension.
- `wb_ack_i`, `wb_err_i` in 1 each: slave responses.
- `frame_done` out 1: one-cycle pulse when the last word of a frame completes.
- `bus_error` out 1: sticky flag, cleared only by reset.

## Operation
States:
- **IDLE → FETCH**: when `enable & fifo_pack_available`. In that same cycle, clear the beat counter, and if the word index is 0, latch `frame_base`.
- **FETCH**: wait until the head is valid, then capture `fifo_data` into `wb_dat_o` and pulse `fifo_r_ack` in the same cycle. Go to **STB**.
  - The head is valid immediately for beat 0.
  - For later beats it is valid `FIFO_LAT` cycles after the previous pop.
- **STB**: hold `wb_stb_o` high with stable address and data until `wb_ack_i` or `wb_err_i`. Then:
  - Increment the word index, which wraps to 0 at `FRAME_WORDS`.
  - If the beat was the last of the packet (beat `NB_PACK-1`), go to IDLE; otherwise go to FETCH.

Bus signals:
- `wb_cyc_o` stays high from the first FETCH until the last response of the packet.
- `wb_we_o` = `wb_cyc_o`.
- `wb_sel_o` = 4'hF while `wb_cyc_o` is high.
- `wb_bte_o` = 0 (linear).

Addressing:
- `wb_adr_o` = latched base + (word index << 2), computed modulo 2^32.
- The word index counter is sized `$clog2(FRAME_WORDS)` bits.

Boundary conditions:
- **Error response** (`wb_err_i`): the word counts as consumed (it is not retried), the address still advances, and `bus_error` is set to 1. If `wb_ack_i` and `wb_err_i` arrive together, treat it as an error.
- **Frame end**: `frame_done` pulses in the cycle after the response to word `FRAME_WORDS-1`. The next packet then re-latches `frame_base`.
- **`enable` falls mid-packet**: the current packet completes.
- **`frame_base` changes mid-frame**: ignored until the next frame starts.
- **`nRST` asserted mid-burst**: immediate return to IDLE. The word index, data, and outputs clear. Any partial packet is abandoned, and the FIFO must be reset alongside this block.

## Timing
- Reset values: every output is 0 and the latched base is 0.
- A packet starts one cycle after `fifo_pack_available & enable` is seen in IDLE.
- Minimum beat period:
  - Beat 0: 2 cycles (FETCH plus STB with a zero-wait ack).
  - Later beats: `FIFO_LAT`+1 cycles.
- Back-to-back packets: IDLE lasts at least one cycle between packets.
- `fifo_r_ack` is never asserted in consecutive cycles, and never more than `NB_PACK` times per packet.

## Configuration
Macro `VIDEO_IN_WB_BURST_EN`:
- **Defined**: `wb_cti_o` = 3'b010 (incrementing burst) on every beat except the last, which carries 3'b111.
- **Undefined**: `wb_cti_o` = 3'b000 (classic cycle) on all beats.

Everything else is identical in both builds.

## Structure
- Package `video_in_pkg` holds:
  - the state enum (IDLE, FETCH, STB);
  - the CTI constants (`CTI_CLASSIC`, `CTI_INCR`, `CTI_EOB`);
  - the defaults for `NB_PACK` and `FRAME_WORDS`, shared with the FIFO.
- One sub-module, `video_in_addr_gen`, owns the base latch, the word index counter with its wrap, and generation of `wb_adr_o` and `frame_done`.

## Test plan
- **Single packet**: `NB_PACK`=16, `frame_base`=0x1000_0000, zero-wait ack. Expect 16 writes at 0x1000_0000..0x1000_003C carrying the FIFO data in order, 16 `fifo_r_ack` pulses, and `wb_cyc_o` high throughout.
- **Slave wait states**: ack delayed 3 cycles on each beat. Expect address and data to stay stable while `wb_stb_o` is held, and no extra pops.
- **Frame wrap**: `FRAME_WORDS`=32, three packets. Expect `frame_done` after the second packet, and the third packet writing from a newly latched `frame_base` of 0x2000_0000.
- **Bus error**: `wb_err_i` on beat 5. Expect `bus_error`=1 and beat 6 at base+0x18, with the packet still completing 16 beats.
- **CTI build check**: with `VIDEO_IN_WB_BURST_EN` defined, expect CTI 010×15 then 111. Without it, expect 000 on all 16 beats.
- **Reset mid-burst**: `nRST` pulsed low at beat 7. Expect all outputs 0 asynchronously, then IDLE until `fifo_pack_available` is seen again.

Source files
------------

// File: rtl/video_in_pkg.sv
// rtl/video_in_pkg.sv - shared state, CTI and sizing constants for the video-in path
package video_in_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STB
    } wr_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int NB_PACK_DEF     = 16;
    localparam int FRAME_WORDS_DEF = 76800;

endpackage

// File: rtl/video_in_addr_gen.sv
// rtl/video_in_addr_gen.sv - frame base latch, wrapping word index, write address and frame_done
module video_in_addr_gen
    import video_in_pkg::*;
#(
    parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        start,
    input  logic        advance,
    input  logic [31:0] frame_base,
    output logic [31:0] wb_adr_o,
    output logic        frame_done
);

    localparam int IDX_W = $clog2(FRAME_WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_WORDS - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      base_q, base_d;
    logic             frame_done_q, frame_done_d;

    always_comb begin
        idx_d        = idx_q;
        base_d       = base_q;
        frame_done_d = 1'b0;
        // A new frame begins only when a packet starts at word 0.
        if (start && (idx_q == '0)) begin
            base_d = frame_base;
        end
        if (advance) begin
            frame_done_d = (idx_q == IDX_LAST);
            idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            idx_q        <= '0;
            base_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            base_q       <= base_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wb_adr_o   = base_q + (32'(idx_q) << 2);
    assign frame_done = frame_done_q;

endmodule

// File: rtl/video_in_wb_writer.sv
// rtl/video_in_wb_writer.sv - FIFO-to-Wishbone packet burst writer; VIDEO_IN_WB_BURST_EN selects burst CTI
module video_in_wb_writer
    import video_in_pkg::*;
#(
    parameter int DATA_SIZE   = 32,
    parameter int NB_PACK     = NB_PACK_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int FIFO_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 enable,
    input  logic [31:0]          frame_base,
    input  logic [DATA_SIZE-1:0] fifo_data,
    input  logic                 fifo_pack_available,
    output logic                 fifo_r_ack,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [31:0]          wb_adr_o,
    output logic [DATA_SIZE-1:0] wb_dat_o,
    output logic [3:0]           wb_sel_o,
    output logic [2:0]           wb_cti_o,
    output logic [1:0]           wb_bte_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    output logic                 frame_done,
    output logic                 bus_error
);

    localparam int BEAT_W = (NB_PACK > 1) ? $clog2(NB_PACK) : 1;
    localparam int WAIT_W = (FIFO_LAT > 0) ? $clog2(FIFO_LAT + 1) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NB_PACK - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(FIFO_LAT);

    wr_state_e             state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [DATA_SIZE-1:0]  dat_q, dat_d;
    logic                  bus_err_q, bus_err_d;
    logic                  pop, start, advance, head_valid, last_beat;

    assign last_beat  = (beat_q == BEAT_LAST);
    // Beat 0 always finds a settled head; later beats wait out the FIFO read latency.
    assign head_valid = (beat_q == '0) || (wait_q == '0);

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wait_d    = (wait_q != '0) ? wait_q - WAIT_W'(1) : wait_q;
        dat_d     = dat_q;
        bus_err_d = bus_err_q;
        pop       = 1'b0;
        start     = 1'b0;
        advance   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && fifo_pack_available) begin
                    start   = 1'b1;
                    beat_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (head_valid) begin
                    pop     = 1'b1;
                    dat_d   = fifo_data;
                    wait_d  = WAIT_INIT;
                    state_d = STB;
                end
            end
            STB: begin
                if (wb_ack_i || wb_err_i) begin
                    advance = 1'b1;
                    if (wb_err_i) begin
                        bus_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            wait_q    <= '0;
            dat_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            dat_q     <= dat_d;
            bus_err_q <= bus_err_d;
        end
    end

    video_in_addr_gen #(
        .FRAME_WORDS(FRAME_WORDS)
    ) u_addr_gen (
        .clk        (clk),
        .nRST       (nRST),
        .start      (start),
        .advance    (advance),
        .frame_base (frame_base),
        .wb_adr_o   (wb_adr_o),
        .frame_done (frame_done)
    );

    assign fifo_r_ack = pop;
    assign wb_cyc_o   = (state_q != IDLE);
    assign wb_stb_o   = (state_q == STB);
    assign wb_we_o    = wb_cyc_o;
    assign wb_sel_o   = wb_cyc_o ? 4'hF : 4'h0;
    assign wb_bte_o   = 2'b00;
    assign wb_dat_o   = dat_q;
    assign bus_error  = bus_err_q;

`ifdef VIDEO_IN_WB_BURST_EN
    assign wb_cti_o = !wb_cyc_o ? CTI_CLASSIC : (last_beat ? CTI_EOB : CTI_INCR);
`else
    assign wb_cti_o = CTI_CLASSIC;
`endif

endmodule

// File: tb/tb_video_in_wb_writer.sv
// tb/tb_video_in_wb_writer.sv - directed self-checking bench for video_in_wb_writer
module tb_video_in_wb_writer;

    localparam int NB_PACK     = 16;
    localparam int FRAME_WORDS = 32;
    localparam int FIFO_LAT    = 2;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] frame_base = 32'h0;
    logic [31:0] fifo_data;
    logic        fifo_pack_available = 1'b0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        fifo_r_ack, wb_cyc_o, wb_stb_o, wb_we_o, frame_done, bus_error;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;

    int checks = 0;
    int fails  = 0;

    video_in_wb_writer #(
        .DATA_SIZE(32), .NB_PACK(NB_PACK), .FRAME_WORDS(FRAME_WORDS), .FIFO_LAT(FIFO_LAT)
    ) dut (
        .clk(clk), .nRST(nRST), .enable(enable), .frame_base(frame_base),
        .fifo_data(fifo_data), .fifo_pack_available(fifo_pack_available),
        .fifo_r_ack(fifo_r_ack), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .frame_done(frame_done),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int k);
        return 32'hD000_0000 + 32'(k * 7 + 1);
    endfunction

    // FIFO model: head shows garbage until FIFO_LAT+1 cycles after a pop.
    int rd_ptr = 0;
    int gap = 0;
    bit pend = 1'b0;
    assign fifo_data = (gap == 0) ? pat(rd_ptr) : 32'hBAD0_BAD0;

    always @(negedge clk) begin
        if (!nRST) begin
            rd_ptr = 0; gap = 0; pend = 1'b0;
        end else begin
            if (pend) begin
                rd_ptr = rd_ptr + 1; gap = FIFO_LAT; pend = 1'b0;
            end else if (gap > 0) begin
                gap = gap - 1;
            end
            if (fifo_r_ack) pend = 1'b1;
        end
    end

    logic [31:0] rec_adr [64];
    logic [31:0] rec_dat [64];
    logic [2:0]  rec_cti [64];
    logic        rec_cyc [64];
    logic        rec_berr[64];
    int pop_cyc[64];
    int npops, nstarts, consec, stab_err, idle_gaps, fd_count, fd_beat;
    int first_cyc_at, first_pop_at, tmo;

    task automatic do_reset();
        nRST = 1'b0; enable = 1'b0; fifo_pack_available = 1'b0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_packets(input int npk, input int waits, input int err_beat,
                               input int both_beat, input int abort_beat, input int sw_beat,
                               input logic [31:0] sw_base, input int en_drop_beat);
        int beats, wcnt, cyc;
        logic prev_cyc, prev_ack;
        beats = 0; wcnt = 0; cyc = 0; prev_cyc = 1'b0; prev_ack = 1'b0;
        npops = 0; nstarts = 0; consec = 0; stab_err = 0; idle_gaps = 0;
        fd_count = 0; fd_beat = -1; first_cyc_at = -1; first_pop_at = -1; tmo = 0;
        fifo_pack_available = 1'b1;
        while (beats < npk * NB_PACK && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            wb_ack_i = 1'b0; wb_err_i = 1'b0;
            if (wb_cyc_o && !prev_cyc) begin
                nstarts++;
                if (first_cyc_at < 0) first_cyc_at = cyc;
            end
            if (!wb_cyc_o && nstarts > 0) idle_gaps++;
            if (nstarts >= npk) fifo_pack_available = 1'b0;
            if (fifo_r_ack) begin
                if (npops < 64) pop_cyc[npops] = cyc;
                npops++;
                if (first_pop_at < 0) first_pop_at = cyc;
                if (prev_ack) consec++;
            end
            prev_ack = fifo_r_ack; prev_cyc = wb_cyc_o;
            if (frame_done) begin fd_count++; fd_beat = beats; end
            if (wb_stb_o) begin
                if (beats == abort_beat) return;
                if (wcnt == 0) begin
                    rec_adr[beats] = wb_adr_o; rec_dat[beats] = wb_dat_o;
                    rec_cti[beats] = wb_cti_o; rec_cyc[beats] = wb_cyc_o;
                    rec_berr[beats] = bus_error;
                end else if (wb_adr_o !== rec_adr[beats] || wb_dat_o !== rec_dat[beats]) begin
                    stab_err++;
                end
                if (wcnt == waits) begin
                    if (beats % NB_PACK == err_beat) wb_err_i = 1'b1;
                    else if (beats % NB_PACK == both_beat) begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
                    else wb_ack_i = 1'b1;
                    if (beats == sw_beat) frame_base = sw_base;
                    if (beats == en_drop_beat) enable = 1'b0;
                    beats++; wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
        if (cyc >= 3000) tmo = 1;
        @(negedge clk);
        wb_ack_i = 1'b0; wb_err_i = 1'b0; fifo_pack_available = 1'b0;
        if (frame_done) begin fd_count++; fd_beat = beats; end
    endtask

    task automatic test_reset();
        int busy;
        nRST = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, fifo_r_ack, frame_done, bus_error, wb_sel_o, wb_cti_o, wb_bte_o} !== 17'h0) begin
            fails++; $display("FAIL reset_ctrl got=%h exp=0", {wb_cyc_o, wb_stb_o, wb_we_o, fifo_r_ack, frame_done, bus_error, wb_sel_o, wb_cti_o, wb_bte_o});
        end
        checks++;
        if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin
            fails++; $display("FAIL reset_adr_dat got=%h/%h exp=0/0", wb_adr_o, wb_dat_o);
        end
        do_reset();
        enable = 1'b1; busy = 0;
        repeat (5) begin @(negedge clk); if (wb_cyc_o || fifo_r_ack) busy++; end
        checks++;
        if (busy !== 0) begin fails++; $display("FAIL idle_no_pack got=%0d exp=0", busy); end
    endtask

    task automatic test_single_packet();
        int bad_adr, bad_dat, bad_cyc;
        do_reset();
        frame_base = 32'h1000_0000; enable = 1'b1;
        run_packets(1, 0, -1, -1, -1, -1, 32'h0, -1);
        bad_adr = 0; bad_dat = 0; bad_cyc = 0;
        for (int k = 0; k < NB_PACK; k++) begin
            checks++;
            if (rec_adr[k] !== 32'h1000_0000 + 32'(4 * k) || rec_dat[k] !== pat(k)) begin
                fails++; $display("FAIL single_beat%0d got=%h/%h exp=%h/%h", k, rec_adr[k], rec_dat[k], 32'h1000_0000 + 32'(4 * k), pat(k));
            end
            if (rec_cyc[k] !== 1'b1) bad_cyc++;
        end
        checks++; if (tmo !== 0) begin fails++; $display("FAIL single_timeout got=%0d exp=0", tmo); end
        checks++; if (npops !== 16) begin fails++; $display("FAIL single_pops got=%0d exp=16", npops); end
        checks++; if (nstarts !== 1 || bad_cyc !== 0) begin fails++; $display("FAIL single_cyc starts=%0d drops=%0d exp=1/0", nstarts, bad_cyc); end
        checks++; if (first_cyc_at !== 1 || first_pop_at !== 1) begin fails++; $display("FAIL single_start got=%0d/%0d exp=1/1", first_cyc_at, first_pop_at); end
        checks++; if (pop_cyc[1] - pop_cyc[0] !== 3 || pop_cyc[15] - pop_cyc[14] !== 3) begin
            fails++; $display("FAIL single_period got=%0d/%0d exp=3/3", pop_cyc[1] - pop_cyc[0], pop_cyc[15] - pop_cyc[14]);
        end
        checks++; if (consec !== 0) begin fails++; $display("FAIL single_consec_pop got=%0d exp=0", consec); end
        checks++; if (wb_cyc_o !== 1'b0 || wb_sel_o !== 4'h0) begin fails++; $display("FAIL single_end_cyc got=%b/%h exp=0/0", wb_cyc_o, wb_sel_o); end
    endtask

    task automatic test_wait_states();
        do_reset();
        frame_base = 32'h0000_4000; enable = 1'b1;
        run_packets(1, 3, -1, -1, -1, -1, 32'h0, -1);
        checks++; if (tmo !== 0) begin fails++; $display("FAIL wait_timeout got=%0d exp=0", tmo); end
        checks++; if (stab_err !== 0) begin fails++; $display("FAIL wait_stable got=%0d exp=0", stab_err); end
        checks++; if (npops !== 16) begin fails++; $display("FAIL wait_pops got=%0d exp=16", npops); end
        checks++; if (rec_adr[15] !== 32'h0000_403C || rec_dat[15] !== pat(15)) begin
            fails++; $display("FAIL wait_last got=%h/%h exp=%h/%h", rec_adr[15], rec_dat[15], 32'h0000_403C, pat(15));
        end
    endtask

    task automatic test_frame_wrap();
        do_reset();
        frame_base = 32'h1000_0000; enable = 1'b1;
        run_packets(3, 0, -1, -1, -1, 4, 32'h2000_0000, -1);
        checks++; if (tmo !== 0) begin fails++; $display("FAIL wrap_timeout got=%0d exp=0", tmo); end
        checks++; if (fd_count !== 1 || fd_beat !== 32) begin fails++; $display("FAIL wrap_frame_done got=%0d@%0d exp=1@32", fd_count, fd_beat); end
        checks++; if (rec_adr[16] !== 32'h1000_0040 || rec_adr[31] !== 32'h1000_007C) begin
            fails++; $display("FAIL wrap_pkt2_adr got=%h/%h exp=10000040/1000007c", rec_adr[16], rec_adr[31]);
        end
        checks++; if (rec_adr[32] !== 32'h2000_0000 || rec_adr[47] !== 32'h2000_003C) begin
            fails++; $display("FAIL wrap_pkt3_adr got=%h/%h exp=20000000/2000003c", rec_adr[32], rec_adr[47]);
        end
        checks++; if (rec_dat[40] !== pat(40)) begin fails++; $display("FAIL wrap_dat got=%h exp=%h", rec_dat[40], pat(40)); end
        checks++; if (nstarts !== 3 || idle_gaps !== 2 || npops !== 48) begin
            fails++; $display("FAIL wrap_b2b got=%0d/%0d/%0d exp=3/2/48", nstarts, idle_gaps, npops);
        end
    endtask

    task automatic test_bus_error();
        do_reset();
        frame_base = 32'h3000_0000; enable = 1'b1;
        run_packets(1, 0, 5, 9, -1, -1, 32'h0, -1);
        checks++; if (tmo !== 0 || npops !== 16) begin fails++; $display("FAIL err_complete got=%0d/%0d exp=0/16", tmo, npops); end
        checks++; if (rec_berr[5] !== 1'b0 || rec_berr[6] !== 1'b1) begin fails++; $display("FAIL err_flag got=%b/%b exp=0/1", rec_berr[5], rec_berr[6]); end
        checks++; if (rec_adr[6] !== 32'h3000_0018 || rec_dat[6] !== pat(6)) begin
            fails++; $display("FAIL err_beat6 got=%h/%h exp=30000018/%h", rec_adr[6], rec_dat[6], pat(6));
        end
        checks++; if (rec_adr[10] !== 32'h3000_0028 || rec_dat[10] !== pat(10)) begin
            fails++; $display("FAIL err_both_beat10 got=%h/%h exp=30000028/%h", rec_adr[10], rec_dat[10], pat(10));
        end
        repeat (3) @(negedge clk);
        checks++; if (bus_error !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b exp=1", bus_error); end
    endtask

    task automatic test_cti();
        logic [2:0] exp_cti;
        do_reset();
        frame_base = 32'h0000_8000; enable = 1'b1;
        run_packets(1, 0, -1, -1, -1, -1, 32'h0, -1);
        for (int k = 0; k < NB_PACK; k++) begin
`ifdef VIDEO_IN_WB_BURST_EN
            exp_cti = (k == NB_PACK - 1) ? 3'b111 : 3'b010;
`else
            exp_cti = 3'b000;
`endif
            checks++;
            if (rec_cti[k] !== exp_cti) begin fails++; $display("FAIL cti_beat%0d got=%b exp=%b", k, rec_cti[k], exp_cti); end
        end
    endtask

    task automatic test_enable_drop();
        int busy;
        do_reset();
        frame_base = 32'h5000_0000; enable = 1'b1;
        run_packets(1, 0, -1, -1, -1, -1, 32'h0, 2);
        checks++; if (tmo !== 0 || npops !== 16) begin fails++; $display("FAIL endrop_complete got=%0d/%0d exp=0/16", tmo, npops); end
        checks++; if (rec_adr[15] !== 32'h5000_003C) begin fails++; $display("FAIL endrop_last got=%h exp=5000003c", rec_adr[15]); end
        fifo_pack_available = 1'b1; busy = 0;
        repeat (6) begin @(negedge clk); if (wb_cyc_o || fifo_r_ack) busy++; end
        fifo_pack_available = 1'b0;
        checks++; if (busy !== 0) begin fails++; $display("FAIL endrop_no_start got=%0d exp=0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        int busy;
        do_reset();
        frame_base = 32'h6000_0000; enable = 1'b1;
        run_packets(1, 0, -1, -1, 7, -1, 32'h0, -1);
        checks++; if (rec_adr[6] !== 32'h6000_0018) begin fails++; $display("FAIL rstmid_pre got=%h exp=60000018", rec_adr[6]); end
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, fifo_r_ack, wb_sel_o, wb_cti_o} !== 10'h0) begin
            fails++; $display("FAIL rstmid_ctrl got=%h exp=0", {wb_cyc_o, wb_stb_o, wb_we_o, fifo_r_ack, wb_sel_o, wb_cti_o});
        end
        checks++; if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin fails++; $display("FAIL rstmid_adr_dat got=%h/%h exp=0/0", wb_adr_o, wb_dat_o); end
        fifo_pack_available = 1'b0;
        repeat (2) @(negedge clk);
        nRST = 1'b1; busy = 0;
        repeat (4) begin @(negedge clk); if (wb_cyc_o || fifo_r_ack) busy++; end
        checks++; if (busy !== 0) begin fails++; $display("FAIL rstmid_idle got=%0d exp=0", busy); end
        run_packets(1, 0, -1, -1, -1, -1, 32'h0, -1);
        checks++; if (tmo !== 0 || npops !== 16) begin fails++; $display("FAIL rstmid_restart got=%0d/%0d exp=0/16", tmo, npops); end
        checks++; if (rec_adr[0] !== 32'h6000_0000 || rec_dat[0] !== pat(0)) begin
            fails++; $display("FAIL rstmid_first got=%h/%h exp=60000000/%h", rec_adr[0], rec_dat[0], pat(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_packet();
        test_wait_states();
        test_frame_wrap();
        test_bus_error();
        test_cti();
        test_enable_drop();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
